nand_xor_pipe: RTL and testbench
================================

Name: nand_xor_pipe

Overview:
- Parametrised, pipelined successor to the single-bit 4-NAND XOR cell.
- Applies XOR, XNOR, running-XOR accumulate or parity-reduce to two WIDTH-bit operands.
- Carries results through STAGES register stages with a valid/ready handshake on both sides.
- Serves as the XOR/parity datapath element for the vedic multiplier's adder and check logic.

Parameters:
- WIDTH, 8, operand and result width in bits (1..32).
- STAGES, 2, pipeline register stages from input accept to output (1..4).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block accepts a beat this cycle; a beat transfers when in_valid & in_ready.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_mode  input  2  0=XOR, 1=XNOR, 2=ACC, 3=PAR.
- in_last  input  1  ACC mode only: final beat of an accumulation run.
- acc_clear  input  1  synchronous clear of the accumulator.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts; a result transfers when out_valid & out_ready.
- out_data  output  WIDTH  result.
- out_parity  output  1  XOR-reduce of out_data.

Behaviour:
- Datapath: each bit of in_a^in_b is built as the four-NAND XOR cell (n1=NAND(a,b); x=NAND(NAND(a,n1),NAND(b,n1))).
- Per-mode result r, computed at the accept cycle:
  - XOR: r = a^b.
  - XNOR: r = ~(a^b).
  - ACC: acc_next = acc ^ a ^ b; r = acc_next.
  - PAR: r = {(WIDTH-1)'b0, ^(a^b)}.
- out_parity = ^r for every mode, carried with the beat.
- Accumulator:
  - WIDTH-bit register, updated only on an accepted ACC beat.
  - ACC beat with in_last=1: r still includes the beat, then acc <= 0.
  - Non-ACC beats leave acc unchanged.
  - acc_clear alone: acc <= 0 at the next edge.
  - acc_clear together with an accepted ACC beat: the beat sees acc=0, so r = a^b and acc <= a^b (or 0 if in_last).
- Pipeline:
  - STAGES stages, each holding a valid bit, data and parity.
  - A stage loads when it is empty or its contents move forward the same cycle.
  - in_ready = stage 0 can load; this may depend combinationally on out_ready.
  - out_valid/out_data/out_parity come directly from the last stage's registers (no combinational path from inputs).
- Latency and throughput:
  - With out_ready held high, a beat accepted at edge k appears with out_valid=1 after edge k+STAGES-1, i.e. STAGES cycles after accept.
  - Throughput is one beat per cycle.
- Backpressure:
  - While out_valid & !out_ready, out_data/out_parity are held stable.
  - With out_ready low, exactly STAGES beats are accepted, then in_ready=0.
  - Order is preserved; no beat is lost or duplicated.
- Ignored inputs: in_last is ignored outside ACC mode. in_mode and inputs are ignored when no transfer occurs.
- Reset (rst_n=0, asynchronous, effective without a clock edge):
  - All stage valid bits 0 (out_valid=0), all stage data 0 (out_data=0, out_parity=0), acc=0.
  - in_ready=1 from the first cycle after release.
  - Reset mid-operation discards all in-flight beats and the accumulator.
- Mode change between beats needs no bubble; each beat carries its own mode.

Test Plan:
- Reset: rst_n=0 with pipeline full -> out_valid=0, out_data=0x00, out_parity=0 before the next clk edge; after release in_ready=1.
- XOR/XNOR (WIDTH=8, STAGES=2, out_ready=1):
  - a=0xA5, b=0x0F, mode 0 -> out_data=0xAA, out_parity=0, out_valid 2 cycles after accept.
  - Same operands, mode 1 -> 0x55, out_parity=0.
- ACC run:
  - Beats (0x01,0x00), (0x02,0x00), (0x04,0x80,last=1) -> 0x01, 0x03, 0x87 (out_parity 1, 0, 0).
  - Next ACC beat (0x10,0x00) -> 0x10.
  - acc_clear coincident with ACC beat (0x03,0x00) after acc=0x87 -> 0x03.
- PAR: a=0x07, b=0x00 -> out_data=0x01, out_parity=1. a=0xFF, b=0x0F -> 0x00, out_parity=0.
- Backpressure:
  - out_ready=0, in_valid=1 for 4 cycles with XOR beats 0x11, 0x22, 0x33, 0x44 (b=0) -> only 0x11 and 0x22 accepted, then in_ready=0.
  - out_data=0x11 stable throughout.
  - Raise out_ready -> 0x11, 0x22 delivered in order, then 0x33, 0x44 accepted and delivered.
- Async reset mid-run: reset pulse between clk edges with acc=0x03 and 2 beats in flight -> out_valid falls immediately; the following ACC beat (0x05,0x00) returns 0x05.

Source files
------------

// File: rtl/nand_xor_pipe.sv
// Pipelined XOR / XNOR / running-XOR accumulate / parity-reduce element built on the
// four-NAND XOR cell, with valid/ready handshakes on both sides.
module nand_xor_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    input  logic             in_last,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity
);

    typedef enum logic [1:0] {
        MODE_XOR  = 2'd0,
        MODE_XNOR = 2'd1,
        MODE_ACC  = 2'd2,
        MODE_PAR  = 2'd3
    } mode_e;

    logic [WIDTH-1:0] nand_ab;
    logic [WIDTH-1:0] x;
    logic             accept;
    mode_e            mode;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] res;

    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0]            go;
    logic [STAGES-1:0][WIDTH-1:0] data_q;
    logic [STAGES-1:0]            par_q;

    // Four-NAND XOR cell, replicated per bit
    assign nand_ab = ~(in_a & in_b);
    assign x       = ~(~(in_a & nand_ab) & ~(in_b & nand_ab));

    assign accept = in_valid & in_ready;
    assign mode   = mode_e'(in_mode);

    // Result and accumulator next-state; a clear coincident with an ACC beat is seen by that beat
    always_comb begin
        acc_base = acc_clear ? '0 : acc_q;
        acc_d    = acc_base;
        res      = x;
        case (mode)
            MODE_XOR:  res = x;
            MODE_XNOR: res = ~x;
            MODE_ACC: begin
                res = acc_base ^ x;
                if (accept) begin
                    acc_d = in_last ? '0 : res;
                end
            end
            default:   res = WIDTH'(^x);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // A stage may load when it, or any stage downstream of it, has a free slot, or the output drains
    for (genvar s = 0; s < STAGES; s++) begin : g_go
        assign go[s] = out_ready | ~(&vld_q[STAGES-1:s]);
    end

    assign in_ready = go[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
            par_q  <= '0;
        end else begin
            if (go[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= res;
                    par_q[0]  <= ^res;
                end
            end
            for (int s = 1; s < int'(STAGES); s++) begin
                if (go[s]) begin
                    vld_q[s] <= vld_q[s-1];
                    if (vld_q[s-1]) begin
                        data_q[s] <= data_q[s-1];
                        par_q[s]  <= par_q[s-1];
                    end
                end
            end
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign out_data   = data_q[STAGES-1];
    assign out_parity = par_q[STAGES-1];

endmodule

// File: tb/tb_nand_xor_pipe.sv
// Self-checking bench for nand_xor_pipe: directed literal cases plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_nand_xor_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned ST = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_mode;
    logic         in_last;
    logic         acc_clear;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_parity;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         p;
    } beat_t;

    beat_t        q[$];
    logic [W-1:0] acc_m;

    nand_xor_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .in_last    (in_last),
        .acc_clear  (acc_clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: model of the spec rules, sampled once per cycle after the falling edge
    initial begin
        logic [W-1:0] x;
        logic [W-1:0] r;
        acc_m = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                q.delete();
                acc_m = '0;
            end else begin
                chk("in_ready", 32'(in_ready), 32'(out_ready || (q.size() < ST)));
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        chk("model data", 32'(out_data), 32'(q[0].d));
                        chk("model parity", 32'(out_parity), 32'(q[0].p));
                        if (out_ready) void'(q.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    x = in_a ^ in_b;
                    case (in_mode)
                        2'd0: r = x;
                        2'd1: r = ~x;
                        2'd2: begin
                            if (acc_clear) acc_m = '0;
                            r = acc_m ^ x;
                            acc_m = in_last ? '0 : r;
                        end
                        default: r = W'(^x);
                    endcase
                    if (acc_clear && in_mode != 2'd2) acc_m = '0;
                    q.push_back('{d: r, p: ^r});
                end else if (acc_clear) begin
                    acc_m = '0;
                end
            end
        end
    end

    // One directed beat with out_ready high; checks latency and the literal result
    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                        input logic last, input logic clr, input logic [W-1:0] exp_d,
                        input logic exp_p, input string name);
        int           lat;
        logic [W-1:0] got_d;
        logic         got_p;
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_mode   = m;
        in_last   = last;
        acc_clear = clr;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        acc_clear = 1'b0;
        lat   = 0;
        got_d = '0;
        got_p = 1'b0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clk);
            #2;
            if (out_valid) begin
                lat   = n;
                got_d = out_data;
                got_p = out_parity;
            end
        end
        chk({name, " latency"}, 32'(lat), 32'(ST));
        chk({name, " data"}, 32'(got_d), 32'(exp_d));
        chk({name, " parity"}, 32'(got_p), 32'(exp_p));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] vals[4];
        logic [W-1:0] got[$];
        int           idx;
        int           ok;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
        in_last = 1'b0; acc_clear = 1'b0; out_ready = 1'b1;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

        // Reset state and release
        repeat (2) @(negedge clk);
        #2;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_parity", 32'(out_parity), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("ready after reset", 32'(in_ready), 32'd1);

        beat(8'hA5, 8'h0F, 2'd0, 1'b0, 1'b0, 8'hAA, 1'b0, "xor");
        beat(8'hA5, 8'h0F, 2'd1, 1'b0, 1'b0, 8'h55, 1'b0, "xnor");
        beat(8'h01, 8'h00, 2'd2, 1'b0, 1'b0, 8'h01, 1'b1, "acc1");
        beat(8'h02, 8'h00, 2'd2, 1'b0, 1'b0, 8'h03, 1'b0, "acc2");
        beat(8'h04, 8'h80, 2'd2, 1'b1, 1'b0, 8'h87, 1'b0, "acc3 last");
        beat(8'h10, 8'h00, 2'd2, 1'b0, 1'b0, 8'h10, 1'b1, "acc after last");
        beat(8'h97, 8'h00, 2'd2, 1'b0, 1'b0, 8'h87, 1'b0, "acc to 87");
        beat(8'h03, 8'h00, 2'd2, 1'b0, 1'b1, 8'h03, 1'b0, "acc with clear");
        beat(8'h07, 8'h00, 2'd3, 1'b0, 1'b0, 8'h01, 1'b1, "par odd");
        beat(8'hFF, 8'h0F, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0, "par even");

        // Backpressure: only STAGES beats enter, head held stable
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a      = vals[idx];
            in_b      = '0;
            in_mode   = 2'd0;
            #2;
            chk("bp in_ready", 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
            if (c >= 2) chk("bp head stable", 32'(out_data), 32'h11);
            if (in_ready) idx++;
        end
        chk("bp accepted", 32'(idx), 32'd2);
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (idx < 4);
            if (idx < 4) in_a = vals[idx];
            #2;
            if (out_valid) got.push_back(out_data);
            if (in_valid && in_ready) idx++;
        end
        chk("bp delivered count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("bp order", (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(vals[i]));
        end

        // Async reset with a full pipeline and acc=0x03
        ok = 0;
        for (int c = 0; c < 6 && ok < 2; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a      = (ok == 0) ? 8'h5A : 8'h3C;
            in_b      = '0;
            in_mode   = 2'd0;
            #2;
            if (in_ready) ok++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("full before reset", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset out_data", 32'(out_data), 32'd0);
        chk("async reset out_parity", 32'(out_parity), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        chk("ready after async reset", 32'(in_ready), 32'd1);
        beat(8'h05, 8'h00, 2'd2, 1'b0, 1'b0, 8'h05, 1'b0, "acc after reset");

        // Randomized traffic, checked by the compare process
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_mode   = 2'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            acc_clear = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        chk("drain model empty", 32'(q.size()), 32'd0);
        chk("drain out_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
